// File: rtl/tt_um_bmsce_project_1.sv
// Registered 2-bit unsigned magnitude comparator tile (1-cycle latency).
// Optional macro CMP_DIFF_EN drives |A-B|, MSB-differ and class-change flags on uio_out.
module tt_um_bmsce_project_1 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef struct packed {
      logic [1:0] max_ab;
      logic       le;
      logic       ge;
      logic       ne;
      logic       lt;
      logic       eq;
      logic       gt;
   } cmp_flags_t;

   logic [1:0] w_a;
   logic [1:0] w_b;
   logic       w_gt;
   logic       w_eq;
   logic       w_lt;
   cmp_flags_t w_flags;
   cmp_flags_t r_flags;
   logic       w_unused;

   assign w_a  = ui_in[1:0];
   assign w_b  = ui_in[3:2];
   assign w_gt = (w_a > w_b);
   assign w_eq = (w_a == w_b);
   assign w_lt = (w_a < w_b);

   assign w_unused = &{1'b0, ui_in[7:4], uio_in};

   always_comb begin
      w_flags        = '0;
      w_flags.gt     = w_gt;
      w_flags.eq     = w_eq;
      w_flags.lt     = w_lt;
      w_flags.ne     = ~w_eq;
      w_flags.ge     = ~w_lt;
      w_flags.le     = ~w_gt;
      w_flags.max_ab = w_gt ? w_a : w_b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_flags <= '0;
      else if (ena)
         r_flags <= w_flags;
   end

   assign uo_out = r_flags;

`ifdef CMP_DIFF_EN
   logic [1:0] w_absdiff;
   logic       w_cls_chg;
   logic [3:0] r_diff;

   assign w_absdiff = w_gt ? (w_a - w_b) : (w_b - w_a);
   // Previous class is the registered gt/eq/lt; after reset it is 000, so the
   // first enabled sample always reports a change.
   assign w_cls_chg = ({w_lt, w_eq, w_gt} != {r_flags.lt, r_flags.eq, r_flags.gt});

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_diff <= '0;
      else if (ena)
         r_diff <= {w_cls_chg, w_a[1] ^ w_b[1], w_absdiff};
   end

   assign uio_out = {4'h0, r_diff};
   assign uio_oe  = 8'h0F;
`else
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_bmsce_project_1.sv
// Directed self-checking bench for the registered 2-bit comparator tile.
module tb_tt_um_bmsce_project_1;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_vec;
   int n_err;

   logic [7:0] exp_tab [16];

   tt_um_bmsce_project_1 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ab(input logic [1:0] a, input logic [1:0] b);
      ui_in = {4'($urandom_range(0, 15)), b, a};
      uio_in = 8'($urandom_range(0, 255));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ena   = 1'b1;
      ui_in = 8'hFF;
      uio_in = 8'hFF;
      tick();
      n_vec++;
      if (uo_out !== 8'h00) begin
         n_err++;
         $display("FAIL reset_uo got=%h exp=%h", uo_out, 8'h00);
      end
      n_vec++;
      if (uio_out !== 8'h00) begin
         n_err++;
         $display("FAIL reset_uio_out got=%h exp=%h", uio_out, 8'h00);
      end
`ifndef CMP_DIFF_EN
      n_vec++;
      if (uio_oe !== 8'h00) begin
         n_err++;
         $display("FAIL reset_uio_oe got=%h exp=%h", uio_oe, 8'h00);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 16; i++) begin
         set_ab(2'(i / 4), 2'(i % 4));
         tick();
         n_vec++;
         if (uo_out !== exp_tab[i]) begin
            n_err++;
            $display("FAIL sweep a=%0d b=%0d got=%b exp=%b", i / 4, i % 4, uo_out, exp_tab[i]);
         end
`ifndef CMP_DIFF_EN
         n_vec++;
         if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            n_err++;
            $display("FAIL sweep_uio got=%h/%h exp=00/00", uio_out, uio_oe);
         end
`endif
      end
   endtask

   task automatic test_latency();
      set_ab(2'd0, 2'd1);
      tick();
      set_ab(2'd3, 2'd1);
      @(negedge clk);
      n_vec++;
      if (uo_out !== 8'h6C) begin
         n_err++;
         $display("FAIL latency_hold got=%h exp=%h", uo_out, 8'h6C);
      end
      tick();
      n_vec++;
      if (uo_out !== 8'hD9) begin
         n_err++;
         $display("FAIL latency_update got=%h exp=%h", uo_out, 8'hD9);
      end
   endtask

   task automatic test_enable_hold();
      set_ab(2'd3, 2'd0);
      tick();
      ena = 1'b0;
      set_ab(2'd0, 2'd3);
      tick();
      tick();
      n_vec++;
      if (uo_out !== 8'hD9) begin
         n_err++;
         $display("FAIL ena_hold got=%h exp=%h", uo_out, 8'hD9);
      end
      ena = 1'b1;
      tick();
      n_vec++;
      if (uo_out !== 8'hEC) begin
         n_err++;
         $display("FAIL ena_resume got=%h exp=%h", uo_out, 8'hEC);
      end
   endtask

   task automatic test_reset_mid();
      set_ab(2'd2, 2'd2);
      tick();
      n_vec++;
      if (uo_out !== 8'hB2) begin
         n_err++;
         $display("FAIL mid_preload got=%h exp=%h", uo_out, 8'hB2);
      end
      rst_n = 1'b0;
      ena   = 1'b0;
      set_ab(2'd1, 2'd1);
      tick();
      n_vec++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         n_err++;
         $display("FAIL mid_reset got=%h/%h exp=00/00", uo_out, uio_out);
      end
      rst_n = 1'b1;
      ena   = 1'b1;
      set_ab(2'd1, 2'd2);
      tick();
      n_vec++;
      if (uo_out !== 8'hAC) begin
         n_err++;
         $display("FAIL mid_release got=%h exp=%h", uo_out, 8'hAC);
      end
   endtask

`ifdef CMP_DIFF_EN
   task automatic test_diff();
      set_ab(2'd1, 2'd0);
      tick();
      set_ab(2'd3, 2'd0);
      tick();
      n_vec++;
      if (uio_out !== 8'h07 || uio_oe !== 8'h0F) begin
         n_err++;
         $display("FAIL diff_gt got=%h/%h exp=07/0f", uio_out, uio_oe);
      end
      set_ab(2'd0, 2'd0);
      tick();
      n_vec++;
      if (uio_out !== 8'h08) begin
         n_err++;
         $display("FAIL diff_chg got=%h exp=%h", uio_out, 8'h08);
      end
      set_ab(2'd1, 2'd2);
      tick();
      n_vec++;
      if (uio_out !== 8'h0D) begin
         n_err++;
         $display("FAIL diff_lt got=%h exp=%h", uio_out, 8'h0D);
      end
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      // index = A*4 + B; {max[1:0], le, ge, ne, lt, eq, gt}
      exp_tab[0]  = 8'h32; exp_tab[1]  = 8'h6C; exp_tab[2]  = 8'hAC; exp_tab[3]  = 8'hEC;
      exp_tab[4]  = 8'h59; exp_tab[5]  = 8'h72; exp_tab[6]  = 8'hAC; exp_tab[7]  = 8'hEC;
      exp_tab[8]  = 8'h99; exp_tab[9]  = 8'h99; exp_tab[10] = 8'hB2; exp_tab[11] = 8'hEC;
      exp_tab[12] = 8'hD9; exp_tab[13] = 8'hD9; exp_tab[14] = 8'hD9; exp_tab[15] = 8'hF2;
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      test_reset();
      test_sweep();
      test_latency();
      test_enable_hold();
      test_reset_mid();
`ifdef CMP_DIFF_EN
      test_diff();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tt_um_bmsce_project_1.md
Name: tt_um_bmsce_project_1

Overview:
Tiny Tapeout user tile implementing a registered 2-bit unsigned magnitude comparator. Operands A and B come in on dedicated inputs; the result flags are registered into uo_out one clock after sampling. Sits directly under the Tiny Tapeout harness with the standard tt_um port set.

Parameters:
None. Operand width is fixed at 2 bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
ena  input  1  tile enable from harness; high = tile selected
ui_in  input  8  [1:0] = A, [3:2] = B, [7:4] unused
uo_out  output  8  registered comparison flags (see Behaviour)
uio_in  input  8  unused; ignored
uio_out  output  8  bidirectional data out; 8'h00 unless CMP_DIFF_EN
uio_oe  output  8  bidirectional output enables; 8'h00 unless CMP_DIFF_EN

Behaviour:
- One clock domain (clk); reset is synchronous and active-low on rst_n. No asynchronous reset path.
- Reset: on any rising clk with rst_n=0, uo_out <= 8'h00, plus any optional-feature registers <= 0. Reset takes priority over ena.
- Operands: A = ui_in[1:0], B = ui_in[3:2], unsigned 0..3. ui_in[7:4] and uio_in do not affect any output.
- Registered flags, updated on each rising clk with rst_n=1 and ena=1:
  - uo_out[0] = A_gt_B (A > B)
  - uo_out[1] = A_eq_B (A == B)
  - uo_out[2] = A_lt_B (A < B)
  - uo_out[3] = A_ne_B
  - uo_out[4] = A_ge_B
  - uo_out[5] = A_le_B
  - uo_out[7:6] = max(A,B)
- Exactly one of uo_out[2:0] is 1 whenever out of reset and at least one enabled clock has occurred.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on uo_out after edge N. The outputs are glitch-free registers with no combinational path from ui_in to uo_out.
- ena=0 with rst_n=1: all output registers hold their value.
- Reset mid-operation: the next rising edge with rst_n=0 forces all outputs to 0. The first enabled edge after release loads fresh flags.
- Without the optional feature, uio_out and uio_oe are constant 8'h00.

Optional Feature:
CMP_DIFF_EN
- Defined:
  - uio_oe = 8'h0F constant.
  - Registered uio_out[1:0] = |A-B|.
  - Registered uio_out[2] = A[1]^B[1] (MSB differs).
  - Registered uio_out[3] = 1 when the compare result class (gt/eq/lt) changed versus the previous enabled sample.
  - All four bits reset to 0 and follow the same reset/ena/latency rules as uo_out.
  - uio_out[7:4] = 0.
- Undefined: uio_out = uio_oe = 8'h00; no extra registers.

Test Plan:
- Reset: rst_n=0 for ≥1 edge with ui_in=8'hFF -> uo_out=8'h00 (and uio_out=8'h00) after the edge.
- Exhaustive sweep: release reset, step A,B through all 16 combos, one cycle each. Check after the next edge:
  - A=2,B=1 -> uo_out[2:0]=3'b001, max=2
  - A=1,B=1 -> 3'b010
  - A=0,B=3 -> 3'b100, max=3, uo_out=8'b11_10_1100
- Latency: change A from 0 to 3 with B=1 between edges -> uo_out unchanged until the next rising edge, then A_gt_B=1.
- Enable hold: load A=3,B=0, drop ena, change to A=0,B=3 -> uo_out holds A_gt_B=1. Raise ena -> A_lt_B=1 after one edge.
- Reset mid-run: with A_eq_B=1 registered, assert rst_n=0 for one edge -> uo_out=8'h00. Ignore ui_in[7:4] toggling throughout (no effect on any flag).
- CMP_DIFF_EN build: A=3,B=0 -> uio_out[1:0]=3, uio_oe=8'h0F. Then A=0,B=0 -> uio_out[1:0]=0, uio_out[3]=1 (class changed gt->eq).
